// File: rtl/sum_splitter.sv
// sum_splitter: takes a loaded total {i_overflow,i_data} and emits it as a
// stream of STEP_W-bit increments. Each beat is the largest step allowed
// (STEP_MAX), and the final beat carries the remainder. The emitted steps
// always sum to the loaded total, so an accumulator fed from reset with this
// stream rebuilds the same value.
//
// Ports
//   clock       rising-edge clock
//   i_rst_n     asynchronous active-low reset
//   i_load      load request, taken only while o_ready=1
//   i_data      low DATA_W bits of the total
//   i_overflow  MSB of the total
//   o_ready     idle; a load is accepted this cycle
//   o_valid     o_step/o_last are valid
//   i_ready     consumer takes the beat when o_valid & i_ready
//   o_step      increment carried by the current beat
//   o_last      current beat is the final one of the transaction
//   o_done      one-cycle pulse once the transaction is complete
module sum_splitter #(
  parameter int DATA_W = 6,
  parameter int STEP_W = 4
) (
  input  logic              clock,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_overflow,
  output logic              o_ready,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [STEP_W-1:0] o_step,
  output logic              o_last,
  output logic              o_done
);

  localparam int TOT_W = DATA_W + 1;
  localparam logic [TOT_W-1:0] STEP_MAX = TOT_W'((1 << STEP_W) - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [TOT_W-1:0] rem, rem_nxt;
  logic             big;
  logic [STEP_W-1:0] step_raw;

  // Every output below is a function of rem/state only, so nothing on the
  // input side can reach an output combinationally.
  assign big      = rem > STEP_MAX;
  assign step_raw = big ? STEP_MAX[STEP_W-1:0] : rem[STEP_W-1:0];

  always_ff @(posedge clock or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
      rem   <= '0;
    end else begin
      state <= state_nxt;
      rem   <= rem_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    o_ready   = 1'b0;
    o_valid   = 1'b0;
    o_step    = '0;
    o_last    = 1'b0;
    o_done    = 1'b0;
    unique case (state)
      IDLE: begin
        o_ready = 1'b1;
        if (i_load) begin
          rem_nxt   = {i_overflow, i_data};
          // A zero total has nothing to emit; go straight to the done pulse.
          state_nxt = ({i_overflow, i_data} == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        o_valid = 1'b1;
        o_step  = step_raw;
        o_last  = !big;
        if (i_ready) begin
          // step_raw <= rem always holds, so this cannot wrap.
          rem_nxt = rem - TOT_W'(step_raw);
          if (!big) state_nxt = DONE;
        end
      end
      DONE: begin
        o_done    = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sum_splitter.sv
// Scoreboard bench for sum_splitter: the driver pushes the expected beat list
// and total for each accepted load; a negedge monitor pops and compares.
module tb_sum_splitter;
  localparam int DATA_W = 6;
  localparam int STEP_W = 4;
  localparam int SMAX   = 15;

  logic              clock = 1'b0;
  logic              i_rst_n = 1'b0;
  logic              i_load = 1'b0;
  logic [DATA_W-1:0] i_data = '0;
  logic              i_overflow = 1'b0;
  logic              o_ready, o_valid, o_last, o_done;
  logic              i_ready = 1'b1;
  logic [STEP_W-1:0] o_step;

  sum_splitter #(.DATA_W(DATA_W), .STEP_W(STEP_W)) dut (
    .clock(clock), .i_rst_n(i_rst_n), .i_load(i_load), .i_data(i_data),
    .i_overflow(i_overflow), .o_ready(o_ready), .o_valid(o_valid),
    .i_ready(i_ready), .o_step(o_step), .o_last(o_last), .o_done(o_done)
  );

  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;

  // Expected beats as {last, step}; expected totals, one per accepted load.
  logic [4:0] exp_q[$];
  int         tot_q[$];

  int rdy_mode = 0;   // 0: always ready, 1: random, 2: driven by main
  int noise    = 0;   // 1: spray ignored loads while busy
  int beats_seen = 0;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: greedy split of the total, largest chunk first.
  task automatic push_expect(input int t);
    int r;
    int s;
    r = t;
    while (r > 0) begin
      s = (r > SMAX) ? SMAX : r;
      exp_q.push_back({(r == s), 4'(s)});
      r -= s;
    end
    tot_q.push_back(t);
  endtask

  // Waits for idle (optionally spraying loads that must be ignored), then
  // issues one load. Returns one cycle after the accepting edge, at edge+1.
  task automatic load(input int t);
    int n;
    n = 0;
    while (!o_ready && n < 300) begin
      i_load     = (noise != 0) ? 1'($urandom % 2) : 1'b0;
      i_data     = 6'($urandom);
      i_overflow = 1'($urandom);
      @(posedge clock); #1;
      n++;
    end
    if (n >= 300) chk("load_wait_timeout", 0, 1);
    i_load = 1'b1;
    {i_overflow, i_data} = 7'(t);
    push_expect(t);
    @(posedge clock); #1;
    i_load = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(o_ready && exp_q.size() == 0 && tot_q.size() == 0) && n < 400) begin
      @(posedge clock); #1;
      n++;
    end
    chk("idle_timeout", int'(n < 400), 1);
  endtask

  always @(posedge clock) begin
    #1;
    if (rdy_mode == 0) i_ready = 1'b1;
    else if (rdy_mode == 1) i_ready = ($urandom % 4) != 0;
  end

  // Monitor
  int         sum = 0;
  int         lastcnt = 0;
  logic       prev_stall = 1'b0;
  logic [3:0] prev_step = '0;
  logic       prev_last = 1'b0;
  logic [4:0] e;
  int         tot;

  always @(negedge clock) begin
    if (!i_rst_n) begin
      sum = 0; lastcnt = 0; prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        chk("stall_valid_held", int'(o_valid), 1);
        chk("stall_step_held", int'(o_step), int'(prev_step));
        chk("stall_last_held", int'(o_last), int'(prev_last));
      end
      if (o_valid && o_done) chk("valid_with_done", 1, 0);
      if (o_valid && i_ready) begin
        beats_seen++;
        if (exp_q.size() == 0) chk("unexpected_beat", int'(o_step), -1);
        else begin
          e = exp_q.pop_front();
          chk("beat_step", int'(o_step), int'(e[3:0]));
          chk("beat_last", int'(o_last), int'(e[4]));
        end
        sum += int'(o_step);
        if (o_last) lastcnt++;
      end
      if (o_done) begin
        if (tot_q.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          tot = tot_q.pop_front();
          chk("sum_of_steps", sum, tot);
          chk("last_count", lastcnt, (tot != 0) ? 1 : 0);
          chk("beats_pending_at_done", exp_q.size(), 0);
        end
        sum = 0; lastcnt = 0;
      end
      prev_stall = o_valid && !i_ready;
      prev_step  = o_step;
      prev_last  = o_last;
    end
  end

  initial begin
    int n;
    int b0;
    int t;
    int r;
    // Reset state
    #12;
    chk("rst_ready", int'(o_ready), 1);
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_step", int'(o_step), 0);
    chk("rst_last", int'(o_last), 0);
    chk("rst_done", int'(o_done), 0);
    @(posedge clock); #1;
    i_rst_n = 1'b1;
    @(posedge clock); #1;

    // 1: 37 -> 15,15,7, done one cycle after the last beat, ready after that
    load(37);
    chk("t1_valid_latency", int'(o_valid), 1);
    n = 0;
    while (!o_done && n < 20) begin @(posedge clock); #1; n++; end
    chk("t1_cycles_to_done", n, 3);
    @(posedge clock); #1;
    chk("t1_ready_after_done", int'(o_ready), 1);

    // 2: 127 -> 8x15 + 7
    load(127);
    wait_idle();

    // 3: zero total -> no beat, done next cycle, idle after
    load(0);
    chk("t3_done", int'(o_done), 1);
    chk("t3_valid", int'(o_valid), 0);
    @(posedge clock); #1;
    chk("t3_ready", int'(o_ready), 1);
    chk("t3_done_one_cycle", int'(o_done), 0);

    // 4: stall 3 cycles on the second beat
    rdy_mode = 2;
    i_ready  = 1'b1;
    load(37);
    @(posedge clock); #1;           // first beat taken
    i_ready = 1'b0;
    repeat (3) begin
      chk("t4_stall_step", int'(o_step), 15);
      chk("t4_stall_last", int'(o_last), 0);
      @(posedge clock); #1;
    end
    i_ready = 1'b1;
    wait_idle();
    rdy_mode = 0;

    // 5: loads during RUN are ignored
    load(37);
    repeat (2) begin
      i_load = 1'b1; i_data = 6'd5; i_overflow = 1'b0;
      @(posedge clock); #1;
    end
    i_load = 1'b0;
    wait_idle();

    // 6: reset mid-transaction, then a clean load of 20
    load(127);
    b0 = beats_seen;
    n = 0;
    while (beats_seen < b0 + 2 && n < 50) begin @(posedge clock); #1; n++; end
    chk("t6_beats_timeout", int'(n < 50), 1);
    @(posedge clock); #3;
    i_rst_n = 1'b0;
    exp_q.delete();
    tot_q.delete();
    #1;
    chk("t6_rst_valid", int'(o_valid), 0);
    chk("t6_rst_ready", int'(o_ready), 1);
    chk("t6_rst_step", int'(o_step), 0);
    chk("t6_rst_last", int'(o_last), 0);
    chk("t6_rst_done", int'(o_done), 0);
    @(posedge clock); #1;
    i_rst_n = 1'b1;
    load(20);
    wait_idle();

    // Randomized mix: stalls, spurious loads, boundary totals
    for (int k = 0; k < 60; k++) begin
      rdy_mode = int'($urandom % 2);
      noise    = int'($urandom % 2);
      r = int'($urandom % 8);
      case (r)
        0: t = 0;
        1: t = 127;
        2: t = 15;
        3: t = 16;
        default: t = int'($urandom % 128);
      endcase
      load(t);
    end
    noise = 0;
    wait_idle();
    rdy_mode = 0;
    chk("final_exp_empty", exp_q.size(), 0);
    chk("final_tot_empty", tot_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
